router_pkt_reader: RTL and testbench

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

---
 rtl/router_pkg.sv | 15 +
 rtl/router_rd_skid.sv | 61 ++++++
 rtl/router_pkt_reader.sv | 160 ++++++++++++++++
 tb/tb_router_pkt_reader.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: shared widths and classifier state encoding
// for the router packet reader slice.
package router_pkg;

  localparam int DW     = 8;
  localparam int LEN_W  = 6;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/router_rd_skid.sv
// router_rd_skid: 2-entry FIFO output buffer with push/pop/flush.
// Ports: push/push_data in, pop in, flush in, head/count out.
module router_rd_skid #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains router FIFO, frames packets (sop/eop),
// checks parity (macro ROUTER_PARITY_CHK_EN), soft-resets on client stall.
// Ports: fifo_empty/fifo_dout in, fifo_rd_en out; dout/vld_out/sop/eop
// out, rd_ready in; parity_err and soft_reset one-cycle pulses out.
module router_pkt_reader #(
  parameter int TIMEOUT = 30,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic [DW-1:0] dout,
  output logic          vld_out,
  input  logic          rd_ready,
  output logic          sop,
  output logic          eop,
  output logic          parity_err,
  output logic          soft_reset
);

  import router_pkg::*;

  localparam int W  = DW + 3;
  localparam int TW = $clog2(TIMEOUT + 1);

  rd_state_e      state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic           inflight_q, inflight_d;
  logic [TW-1:0]  stall_q, stall_d;

  logic [W-1:0]   head;
  logic [W-1:0]   push_data;
  logic [1:0]     count;
  logic [1:0]     occ_after;
  logic           push, pop, stalled;
  logic           tag_sop, tag_eop, tag_err;

`ifdef ROUTER_PARITY_CHK_EN
  logic [DW-1:0]  xor_q, xor_d;
`endif

  assign vld_out    = (count != 2'd0);
  assign pop        = vld_out && rd_ready;
  assign stalled    = vld_out && !rd_ready;
  assign soft_reset = stalled && (stall_q == TW'(TIMEOUT - 1));
  assign push       = inflight_q && !soft_reset;

  // Occupancy once this cycle's pop and returning byte settle;
  // counting the pop keeps one byte/cycle with rd_ready high.
  assign occ_after  = count - {1'b0, pop} + {1'b0, inflight_q};
  assign fifo_rd_en = resetn && !fifo_empty
                    && (occ_after < 2'd2) && !soft_reset;
  assign inflight_d = fifo_rd_en;

  assign dout       = head[DW-1:0];
  assign sop        = vld_out && head[DW];
  assign eop        = vld_out && head[DW+1];
  assign parity_err = pop && head[DW+1] && head[DW+2];

  assign push_data  = {tag_err, tag_eop, tag_sop, fifo_dout};

  always_comb begin
    stall_d = '0;
    if (!soft_reset && stalled) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_sop = 1'b0;
    tag_eop = 1'b0;
    tag_err = 1'b0;
`ifdef ROUTER_PARITY_CHK_EN
    xor_d   = xor_q;
`endif
    if (soft_reset) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef ROUTER_PARITY_CHK_EN
      xor_d   = '0;
`endif
    end else if (push) begin
      unique case (state_q)
        ST_IDLE: begin
          tag_sop = 1'b1;
          cnt_d   = fifo_dout[ADDR_W +: LEN_W];
`ifdef ROUTER_PARITY_CHK_EN
          xor_d   = fifo_dout;
`endif
          if (fifo_dout[ADDR_W +: LEN_W] != '0) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_PAYLOAD: begin
          cnt_d = cnt_q - 1'b1;
`ifdef ROUTER_PARITY_CHK_EN
          xor_d = xor_q ^ fifo_dout;
`endif
          if (cnt_q == LEN_W'(1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          tag_eop = 1'b1;
`ifdef ROUTER_PARITY_CHK_EN
          tag_err = (fifo_dout != xor_q);
`endif
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
    end
  end

`ifdef ROUTER_PARITY_CHK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  router_rd_skid #(
    .W (W)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (soft_reset),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: directed bench for router_pkt_reader
// with a byte-FIFO model and an output collector.
module tb_router_pkt_reader;

  typedef struct packed {
    logic [31:0] cyc;
    logic        perr;
    logic        eop;
    logic        sop;
    logic [7:0]  d;
  } rx_t;

`ifdef ROUTER_PARITY_CHK_EN
  localparam int EXP_PERR = 1;
`else
  localparam int EXP_PERR = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rd_ready = 1'b1;
  logic       hold_empty = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic [7:0] dout;
  logic       vld_out, sop, eop, parity_err, soft_reset;

  logic [7:0] fmem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_empty_cnt = 0;
  int         perr_cnt = 0;
  int         srst_cnt = 0;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  logic [7:0] exp [$];
  rx_t        rx [$];

  router_pkt_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .dout       (dout),
    .vld_out    (vld_out),
    .rd_ready   (rd_ready),
    .sop        (sop),
    .eop        (eop),
    .parity_err (parity_err),
    .soft_reset (soft_reset)
  );

  always #5 clk = ~clk;

  assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty) begin
        rd_empty_cnt <= rd_empty_cnt + 1;
      end else begin
        fifo_dout <= fmem[rd_ptr[9:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (vld_out && rd_ready) begin
      rx.push_back({32'(cyc), parity_err, eop, sop, dout});
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (soft_reset) srst_cnt <= srst_cnt + 1;
  end

  task automatic make_pkt(input logic [7:0] hdr,
                          input logic [7:0] base,
                          input logic       flip);
    logic [7:0] x;
    logic [7:0] b;
    int n;
    n = int'(hdr[7:2]);
    x = hdr;
    exp.delete();
    exp.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      b = base + 8'(i);
      x = x ^ b;
      exp.push_back(b);
    end
    exp.push_back(x ^ {7'b0, flip});
    foreach (exp[i]) begin
      fmem[wr_ptr[9:0]] = exp[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    while (rx.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    ok = (rx.size() >= n);
  endtask

  function automatic int frame_errs(input int b);
    int e = 0;
    int n = exp.size();
    rx_t r;
    for (int i = 0; i < n; i++) begin
      r = rx[b + i];
      if (r.d !== exp[i] || r.sop !== (i == 0) || r.eop !== (i == n - 1))
        e++;
    end
    return e;
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    make_pkt(8'h01, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({fifo_rd_en, vld_out, sop, eop, parity_err, soft_reset} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {fifo_rd_en, vld_out, sop, eop, parity_err, soft_reset});
    end
    checks++;
    if (dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_dout got=%h want=00", dout);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_len0;
    bit ok;
    int p0 = perr_cnt;
    wait_rx(2, 50, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL len0_timeout got=%0d want=2", rx.size());
    end
    checks++;
    if (frame_errs(0) !== 0) begin
      fails++;
      $display("FAIL len0_frame got=%0d errs want=0", frame_errs(0));
    end
    checks++;
    if (perr_cnt - p0 !== 0) begin
      fails++;
      $display("FAIL len0_perr got=%0d want=0", perr_cnt - p0);
    end
  endtask

  task automatic test_full_pkt;
    bit ok;
    int r0, p0, gap;
    @(posedge clk);
    #1;
    r0 = rx.size();
    p0 = perr_cnt;
    make_pkt(8'h38, 8'h10, 1'b0);
    wait_rx(r0 + 16, 100, ok);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL full_timeout got=%0d want=%0d", rx.size(), r0 + 16);
    end
    checks++;
    if (frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL full_frame got=%0d errs want=0", frame_errs(r0));
    end
    gap = int'(rx[r0 + 15].cyc) - int'(rx[r0].cyc);
    checks++;
    if (gap !== 15) begin
      fails++;
      $display("FAIL full_contig got=%0d cycles want=15", gap);
    end
    checks++;
    if (perr_cnt - p0 !== 0) begin
      fails++;
      $display("FAIL full_perr got=%0d want=0", perr_cnt - p0);
    end
  endtask

  task automatic test_parity_err;
    bit ok;
    int r0, p0;
    @(posedge clk);
    #1;
    r0 = rx.size();
    p0 = perr_cnt;
    make_pkt(8'h38, 8'h40, 1'b1);
    wait_rx(r0 + 16, 100, ok);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (!ok || frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL perr_frame got=%0d bytes want=%0d", rx.size(), r0 + 16);
    end
    checks++;
    if (perr_cnt - p0 !== EXP_PERR) begin
      fails++;
      $display("FAIL perr_count got=%0d want=%0d", perr_cnt - p0, EXP_PERR);
    end
    checks++;
    if (int'(rx[r0 + 15].perr) !== EXP_PERR) begin
      fails++;
      $display("FAIL perr_on_eop got=%0d want=%0d", rx[r0 + 15].perr, EXP_PERR);
    end
  endtask

  task automatic test_stall;
    bit ok;
    int r0, s0, k, early;
    // 29 stalled cycles: no soft reset
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    r0 = rx.size();
    s0 = srst_cnt;
    make_pkt(8'h0C, 8'h70, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld_out && k < 40);
    repeat (28) @(negedge clk);
    @(posedge clk);
    #1 rd_ready = 1'b1;
    wait_rx(r0 + 5, 50, ok);
    checks++;
    if (!ok || frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL stall29_data got=%0d bytes want=%0d", rx.size(), r0 + 5);
    end
    checks++;
    if (srst_cnt - s0 !== 0) begin
      fails++;
      $display("FAIL stall29_srst got=%0d want=0", srst_cnt - s0);
    end
    // 30 stalled cycles: soft reset on the 30th
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    r0 = rx.size();
    make_pkt(8'h0C, 8'h80, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld_out && k < 40);
    checks++;
    if (vld_out !== 1'b1) begin
      fails++;
      $display("FAIL stall30_vld got=%b want=1", vld_out);
    end
    early = 0;
    repeat (28) begin
      @(negedge clk);
      if (soft_reset) early++;
    end
    checks++;
    if (early !== 0) begin
      fails++;
      $display("FAIL stall30_early got=%0d pulses want=0", early);
    end
    @(negedge clk);
    checks++;
    if (soft_reset !== 1'b1) begin
      fails++;
      $display("FAIL stall30_srst got=%b want=1", soft_reset);
    end
    @(posedge clk);
    #1 wr_ptr = rd_ptr;
    @(negedge clk);
    checks++;
    if ({vld_out, soft_reset} !== 2'b00) begin
      fails++;
      $display("FAIL stall30_after got=%b want=00", {vld_out, soft_reset});
    end
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    checks++;
    if (rx.size() !== r0) begin
      fails++;
      $display("FAIL stall30_leak got=%0d want=%0d", rx.size(), r0);
    end
    make_pkt(8'h04, 8'hAA, 1'b0);
    wait_rx(r0 + 3, 50, ok);
    checks++;
    if (!ok || frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL stall30_next got=%0d bytes want=%0d", rx.size(), r0 + 3);
    end
  endtask

  task automatic test_empty_toggle;
    int r0, e0, k;
    @(posedge clk);
    #1;
    r0 = rx.size();
    e0 = rd_empty_cnt;
    make_pkt(8'h18, 8'h21, 1'b0);
    k = 0;
    while (rx.size() < r0 + 8 && k < 200) begin
      @(posedge clk);
      #1;
      if (k % 3 == 2) hold_empty = ~hold_empty;
      k++;
    end
    hold_empty = 1'b0;
    checks++;
    if (rx.size() < r0 + 8) begin
      fails++;
      $display("FAIL empty_timeout got=%0d want=%0d", rx.size(), r0 + 8);
    end
    checks++;
    if (frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL empty_frame got=%0d errs want=0", frame_errs(r0));
    end
    checks++;
    if (rd_empty_cnt - e0 !== 0) begin
      fails++;
      $display("FAIL empty_read got=%0d reads want=0", rd_empty_cnt - e0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int r0, p0, eops;
    @(posedge clk);
    #1;
    r0 = rx.size();
    p0 = perr_cnt;
    make_pkt(8'h38, 8'h50, 1'b0);
    wait_rx(r0 + 6, 50, ok);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, vld_out, sop, eop, parity_err, soft_reset} !== 6'b0 ||
        dout !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_outs got=%b/%h want=000000/00",
               {fifo_rd_en, vld_out, sop, eop, parity_err, soft_reset}, dout);
    end
    wr_ptr = rd_ptr;
    repeat (2) @(posedge clk);
    #1;
    eops = 0;
    for (int i = r0; i < rx.size(); i++) if (rx[i].eop) eops++;
    checks++;
    if (!ok || rx.size() !== r0 + 6 || eops !== 0) begin
      fails++;
      $display("FAIL rstmid_drop got=%0d bytes %0d eop want=%0d bytes 0 eop",
               rx.size() - r0, eops, 6);
    end
    checks++;
    if (perr_cnt - p0 !== 0) begin
      fails++;
      $display("FAIL rstmid_perr got=%0d want=0", perr_cnt - p0);
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    r0 = rx.size();
    make_pkt(8'h09, 8'h33, 1'b0);
    wait_rx(r0 + 4, 50, ok);
    checks++;
    if (!ok || frame_errs(r0) !== 0) begin
      fails++;
      $display("FAIL rstmid_next got=%0d bytes want=%0d", rx.size(), r0 + 4);
    end
  endtask

  initial begin
    test_reset;
    test_len0;
    test_full_pkt;
    test_parity_err;
    test_stall;
    test_empty_toggle;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
